// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame game controller. Runs ATTRACT/PLAY/OVER and
// steps the MOVE, FIRE, ENEMY and COLLIDE units once per VGA frame.
`default_nettype none

module frame_sequencer #(
  parameter int LIVES_INIT = 3,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk_25,
  input  logic             reset_n,
  input  logic             vs,
  input  logic             start,
  input  logic [3:0]       Dir,
  input  logic             fire,
  input  logic [3:0]       done,
  input  logic             hit,
  output logic [3:0]       phase_req,
  output logic [3:0]       dir_lat,
  output logic             fire_lat,
  output logic             obj_clr,
  output logic [1:0]       state,
  output logic             over,
  output logic [1:0]       lives,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_PLAY    = 2'b01,
    ST_OVER    = 2'b10
  } state_t;

  state_t st_q, st_nxt;

  logic             vs_d, start_d;
  logic [TMR_W-1:0] timer_q, timer_nxt;
  logic [3:0]       req_nxt, dir_nxt;
  logic             fire_nxt, clr_nxt, over_nxt, ovr_nxt, terr_nxt;
  logic [1:0]       lives_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  logic       tick, start_rise, busy, phase_done, dir_onehot;
  logic [3:0] req_shift;

  assign tick       = vs & ~vs_d;
  assign start_rise = start & ~start_d;
  assign busy       = (phase_req != 4'd0);
  assign phase_done = ((done & phase_req) != 4'd0);
  assign dir_onehot = (Dir != 4'd0) && ((Dir & (Dir - 4'd1)) == 4'd0);
  // Shifting past COLLIDE naturally yields 0000, which is the idle state.
  assign req_shift  = {phase_req[2:0], 1'b0};

  always_comb begin
    st_nxt    = st_q;
    req_nxt   = phase_req;
    dir_nxt   = dir_lat;
    fire_nxt  = fire_lat;
    clr_nxt   = 1'b0;
    lives_nxt = lives;
    cnt_nxt   = frame_cnt;
    ovr_nxt   = overrun;
    terr_nxt  = timeout_err;
    timer_nxt = timer_q;

    case (st_q)
      ST_ATTRACT, ST_OVER: begin
        req_nxt   = 4'd0;
        timer_nxt = '0;
        if (start_rise) begin
          st_nxt    = ST_PLAY;
          clr_nxt   = 1'b1;
          lives_nxt = LIVES_LOAD;
          cnt_nxt   = '0;
          ovr_nxt   = 1'b0;
          terr_nxt  = 1'b0;
        end
      end

      ST_PLAY: begin
        if (busy) begin
          if (tick) begin
            ovr_nxt = 1'b1;
          end
          if (phase_done) begin
            req_nxt   = req_shift;
            timer_nxt = '0;
            if (phase_req[3] && hit && (lives != 2'd0)) begin
              lives_nxt = lives - 2'd1;
              if (lives == 2'd1) begin
                st_nxt = ST_OVER;
              end
            end
          end else if (timer_q == TMR_LAST) begin
            // A timed-out COLLIDE advances without charging a life.
            req_nxt   = req_shift;
            timer_nxt = '0;
            terr_nxt  = 1'b1;
          end else begin
            timer_nxt = timer_q + TMR_W'(1);
          end
        end else if (tick) begin
          req_nxt   = 4'b0001;
          cnt_nxt   = frame_cnt + CNT_W'(1);
          fire_nxt  = fire;
          dir_nxt   = dir_onehot ? Dir : 4'd0;
          timer_nxt = '0;
        end
      end

      default: begin
        st_nxt    = ST_ATTRACT;
        req_nxt   = 4'd0;
        timer_nxt = '0;
      end
    endcase

    over_nxt = (st_nxt == ST_OVER);
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= ST_ATTRACT;
      vs_d        <= 1'b1;
      start_d     <= 1'b1;
      timer_q     <= '0;
      phase_req   <= 4'd0;
      dir_lat     <= 4'd0;
      fire_lat    <= 1'b0;
      obj_clr     <= 1'b0;
      over        <= 1'b0;
      lives       <= 2'd0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      st_q        <= st_nxt;
      vs_d        <= vs;
      start_d     <= start;
      timer_q     <= timer_nxt;
      phase_req   <= req_nxt;
      dir_lat     <= dir_nxt;
      fire_lat    <= fire_nxt;
      obj_clr     <= clr_nxt;
      over        <= over_nxt;
      lives       <= lives_nxt;
      frame_cnt   <= cnt_nxt;
      overrun     <= ovr_nxt;
      timeout_err <= terr_nxt;
    end
  end

  assign state = st_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized frames checked against a
// frame-level model of lives, frame count, latches and sticky flags.
`timescale 1ns/1ps
`default_nettype none

module tb_frame_sequencer;

  localparam int LIVES_INIT = 3;
  localparam int TIMEOUT    = 16;
  localparam int CNT_W      = 4;

  logic             clk_25 = 1'b0;
  logic             reset_n, vs, start, fire, hit;
  logic [3:0]       Dir, done;
  logic [3:0]       phase_req, dir_lat;
  logic             fire_lat, obj_clr, over, overrun, timeout_err;
  logic [1:0]       state, lives;
  logic [CNT_W-1:0] frame_cnt;

  frame_sequencer #(
    .LIVES_INIT (LIVES_INIT),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_25      (clk_25),
    .reset_n     (reset_n),
    .vs          (vs),
    .start       (start),
    .Dir         (Dir),
    .fire        (fire),
    .done        (done),
    .hit         (hit),
    .phase_req   (phase_req),
    .dir_lat     (dir_lat),
    .fire_lat    (fire_lat),
    .obj_clr     (obj_clr),
    .state       (state),
    .over        (over),
    .lives       (lives),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #20 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model
  int         exp_lives;
  int         exp_frames;
  logic [1:0] exp_state;
  logic       exp_ovr, exp_terr, exp_fire;
  logic [3:0] exp_dir;

  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp_req, input logic exp_clr);
    chk({tag, "/state"},       32'(state),       32'(exp_state));
    chk({tag, "/over"},        32'(over),        32'(exp_state == 2'b10));
    chk({tag, "/lives"},       32'(lives),       32'(exp_lives));
    chk({tag, "/frame_cnt"},   32'(frame_cnt),   32'(exp_frames % (1 << CNT_W)));
    chk({tag, "/overrun"},     32'(overrun),     32'(exp_ovr));
    chk({tag, "/timeout_err"}, 32'(timeout_err), 32'(exp_terr));
    chk({tag, "/dir_lat"},     32'(dir_lat),     32'(exp_dir));
    chk({tag, "/fire_lat"},    32'(fire_lat),    32'(exp_fire));
    chk({tag, "/phase_req"},   32'(phase_req),   32'(exp_req));
    chk({tag, "/obj_clr"},     32'(obj_clr),     32'(exp_clr));
  endtask

  // One frame: tick, then each phase acked after dl cycles (dl<0: never acked).
  // ovr_k raises vs again on the edge that ends phase ovr_k.
  task automatic run_frame(input logic [3:0] d, input logic f, input logic h,
                           input int dl0, input int dl1, input int dl2, input int dl3,
                           input int ovr_k);
    int dl[4];
    dl = '{dl0, dl1, dl2, dl3};
    vs = 1'b1; Dir = d; fire = f;
    step();
    vs = 1'b0;
    exp_frames++;
    exp_dir  = ($countones(d) == 1) ? d : 4'b0000;
    exp_fire = f;
    chk("tick/phase_req", 32'(phase_req), 32'h1);
    chk("tick/frame_cnt", 32'(frame_cnt), 32'(exp_frames % (1 << CNT_W)));
    chk("tick/dir_lat",   32'(dir_lat),   32'(exp_dir));
    chk("tick/fire_lat",  32'(fire_lat),  32'(exp_fire));
    for (int k = 0; k < 4; k++) begin
      int n;
      n = (dl[k] < 0) ? TIMEOUT : dl[k];
      for (int i = 0; i < n - 1; i++) begin
        done = (i == 0) ? ~(4'b0001 << k) : (4'($urandom) & ~(4'b0001 << k));
        hit  = 1'($urandom);
        step();
        chk("hold/phase_req", 32'(phase_req), 32'(1 << k));
      end
      done = (dl[k] >= 0) ? (4'b0001 << k) : 4'b0000;
      hit  = (k == 3) ? h : 1'($urandom);
      vs   = (k == ovr_k);
      step();
      done = 4'b0000; hit = 1'b0; vs = 1'b0;
      if (dl[k] < 0) exp_terr = 1'b1;
      if (k == ovr_k) exp_ovr = 1'b1;
      if (k == 3 && dl[k] >= 0 && h) begin
        exp_lives--;
        if (exp_lives == 0) exp_state = 2'b10;
      end
      chk("adv/phase_req",   32'(phase_req),   (k < 3) ? 32'(1 << (k + 1)) : 32'h0);
      chk("adv/overrun",     32'(overrun),     32'(exp_ovr));
      chk("adv/timeout_err", 32'(timeout_err), 32'(exp_terr));
      chk("adv/lives",       32'(lives),       32'(exp_lives));
    end
    check_all("frame_end", 4'b0000, 1'b0);
    step();
    chk("idle/phase_req", 32'(phase_req), 32'h0);
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 4));
  endfunction

  initial begin
    reset_n = 1'b0; vs = 1'b0; start = 1'b0; Dir = 4'b0000;
    fire = 1'b0; done = 4'b0000; hit = 1'b0;
    exp_lives = 0; exp_frames = 0; exp_state = 2'b00;
    exp_ovr = 1'b0; exp_terr = 1'b0; exp_fire = 1'b0; exp_dir = 4'b0000;

    repeat (3) step();
    check_all("reset", 4'b0000, 1'b0);
    reset_n = 1'b1;
    step();

    // Ticks in ATTRACT produce nothing
    vs = 1'b1; step(); vs = 1'b0;
    check_all("attract_tick", 4'b0000, 1'b0);
    step();
    chk("attract_idle/phase_req", 32'(phase_req), 32'h0);

    // Start game
    start = 1'b1;
    step();
    exp_state = 2'b01; exp_lives = LIVES_INIT; exp_frames = 0;
    check_all("start", 4'b0000, 1'b1);
    step();
    chk("start_held/obj_clr", 32'(obj_clr), 32'h0);
    start = 1'b0; step();
    start = 1'b1; step();
    check_all("start_in_play", 4'b0000, 1'b0);
    start = 1'b0;

    // Directed frames
    run_frame(4'b0010, 1'b1, 1'b0, 2, 2, 2, 2, -1);
    run_frame(4'b0110, 1'b0, 1'b0, 3, 1, 2, 1, -1);
    run_frame(4'b1000, 1'b1, 1'b0, 1, -1, 1, 1, -1);
    run_frame(4'b0001, 1'b0, 1'b0, 2, 3, 2, -1, 1);

    // Randomized frames, no lives lost; carries frame_cnt past its wrap
    for (int r = 0; r < 14; r++) begin
      logic [3:0] d;
      int         ok;
      d = 4'($urandom);
      if ($urandom_range(0, 1) == 1) d = 4'b0001 << $urandom_range(0, 3);
      ok = (r % 5 == 3) ? int'($urandom_range(1, 3)) : -1;
      run_frame(d, 1'($urandom), 1'b0, rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay(), ok);
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("gap/phase_req", 32'(phase_req), 32'h0);
      end
    end

    // Three hits end the game
    run_frame(4'b0100, 1'b0, 1'b1, 1, 1, 1, 2, -1);
    run_frame(4'b1000, 1'b1, 1'b1, 2, 1, 3, 1, -1);
    run_frame(4'b0001, 1'b0, 1'b1, 1, 2, 1, 1, -1);

    // Ticks in OVER produce nothing
    vs = 1'b1; step(); vs = 1'b0;
    check_all("over_tick", 4'b0000, 1'b0);
    repeat (3) begin
      step();
      chk("over_idle/phase_req", 32'(phase_req), 32'h0);
    end

    // Restart from OVER clears the sticky flags and counter
    start = 1'b1;
    step();
    exp_state = 2'b01; exp_lives = LIVES_INIT; exp_frames = 0;
    exp_ovr = 1'b0; exp_terr = 1'b0;
    check_all("restart", 4'b0000, 1'b1);
    start = 1'b0;
    step();
    chk("restart/obj_clr_drop", 32'(obj_clr), 32'h0);

    // Tick on the same edge as done[3] is an overrun, and the hit still counts
    run_frame(4'b0100, 1'b1, 1'b1, 1, 1, 1, 2, 3);

    // Reset mid-phase acts immediately
    vs = 1'b1; Dir = 4'b0100; fire = 1'b0;
    step();
    vs = 1'b0;
    chk("pre_reset/phase_req", 32'(phase_req), 32'h1);
    step();
    #2 reset_n = 1'b0;
    #1;
    exp_state = 2'b00; exp_lives = 0; exp_frames = 0; exp_ovr = 1'b0;
    exp_terr = 1'b0; exp_dir = 4'b0000; exp_fire = 1'b0;
    check_all("async_reset", 4'b0000, 1'b0);

    // Levels already high at release must not look like edges
    vs = 1'b1; start = 1'b1;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check_all("release_high", 4'b0000, 1'b0);
    start = 1'b0; vs = 1'b0;
    step();
    start = 1'b1;
    step();
    exp_state = 2'b01; exp_lives = LIVES_INIT;
    check_all("post_reset_start", 4'b0000, 1'b1);
    start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame game controller for the fighter game. Detects the start of each VGA frame from `vs` and runs the game states: attract, play and game-over. During play it runs the object-update units (player move, bullet fire, enemy move, collision) one after another, using a one-hot request/done handshake. It sits between the key inputs and the airplane, bullet and enemy datapaths, and owns the lives count and the `over` flag.

## Interface
- `LIVES_INIT`, 3: lives loaded at game start; range 1–3.
- `TIMEOUT`, 1024: maximum `clk_25` cycles a phase may stay requested.
- `CNT_W`, 16: width of the frame counter.
- `clk_25` in 1: 25 MHz pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vs` in 1: VGA vertical sync, synchronous to `clk_25`.
- `start` in 1: debounced start key, level, synchronous.
- `Dir` in 4: move keys, one-hot. 1000=up, 0100=down, 0010=left, 0001=right.
- `fire` in 1: fire key, level.
- `done` in 4: completion pulses from the phase units, one bit per phase.
- `hit` in 1: collision result; valid only with `done[3]`.
- `phase_req` out 4: one-hot phase request. Bit 0=MOVE, 1=FIRE, 2=ENEMY, 3=COLLIDE.
- `dir_lat` out 4: `Dir` latched at frame start.
- `fire_lat` out 1: `fire` latched at frame start.
- `obj_clr` out 1: one-cycle pulse that clears all object datapaths.
- `state` out 2: 00=ATTRACT, 01=PLAY, 10=OVER. 11 is never produced.
- `over` out 1: high exactly when `state`=OVER.
- `lives` out 2: remaining lives.
- `frame_cnt` out CNT_W: number of frames sequenced in the current game.
- `overrun` out 1: sticky; a frame tick arrived while a sequence was busy.
- `timeout_err` out 1: sticky; a phase timed out.

## Operation
- Frame tick:
  - `vs` is registered into `vs_d`.
  - tick = `vs & ~vs_d` at a clock edge. This is the rising edge of `vs`.
- Start edge:
  - `start` is registered the same way.
  - start_rise = `start & ~start_d`.
- Game state machine:
  - ATTRACT or OVER, with start_rise:
    - go to PLAY
    - pulse `obj_clr` for one cycle
    - load `lives`=LIVES_INIT
    - clear `frame_cnt`, `overrun` and `timeout_err`
  - ATTRACT or OVER: ticks are ignored; `phase_req` stays 0.
  - PLAY: `start` is ignored.
  - PLAY to OVER: only when a hit consumes the last life (see below).
- Sequencer, active only in PLAY. busy = (`phase_req` != 0) before the edge.
  - Tick with busy=0:
    - `phase_req` <= 0001
    - `frame_cnt` increments; wraps from all-ones to 0
    - `fire_lat` <= `fire`
    - `dir_lat` <= `Dir` if `Dir` is one-hot, otherwise 0000 (stop)
    - phase timer cleared
  - Tick with busy=1: the tick is dropped and `overrun` is set.
  - Active bit k with `done[k]`=1: `phase_req` shifts left by one bit and the timer clears. After bit 3 it becomes 0000 (idle).
  - `done` bits for inactive phases are ignored.
  - Timer reaches TIMEOUT-1 without done: the phase advances exactly as on done, and `timeout_err` is set.
- Lives:
  - On `done[3]` with `hit`=1, `lives` decrements.
  - If `lives` was 1, it becomes 0 and `state` goes to OVER on the same edge that `phase_req` returns to 0000.
  - A COLLIDE timeout never costs a life.
- Reset (`reset_n` low, at any time, including mid-sequence):
  - `state`=ATTRACT; `phase_req`, `dir_lat`, `fire_lat`, `obj_clr`, `lives`, `over`, `frame_cnt`, `overrun`, `timeout_err` = 0
  - `vs_d`=1 and `start_d`=1, so a level already held high at release does not produce an edge.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Tick to `phase_req`=0001: 1 cycle. `vs` high sampled at edge N gives request valid after edge N.
- `done[k]` sampled at edge M: the next bit is valid after edge M. The minimum full sequence is 4 cycles from request to idle.
- A tick on the same edge as `done[3]` is still an overrun, because busy is evaluated before the edge.
- Phase timer: counts cycles with the current bit active and wraps to 0 on advance. Width is clog2(TIMEOUT).
- `obj_clr` is high for exactly the cycle following the start_rise edge.

## Test plan
- Reset, then start_rise → `obj_clr` high for 1 cycle, `state`=01, `lives`=3, `frame_cnt`=0.
- PLAY, `Dir`=0010, `fire`=1, `vs` rises, each done returned 2 cycles after its request:
  - `phase_req` steps 0001 → 0010 → 0100 → 1000 → 0000
  - `dir_lat`=0010, `fire_lat`=1, `frame_cnt`=1
- `Dir`=0110 at a tick → `dir_lat`=0000. `done[2]` pulsed while `phase_req`=0001 → no advance.
- Phase 1 never acknowledged, TIMEOUT=16 → advance to 0100 16 cycles after the request; `timeout_err`=1 and stays set.
- Three frames with `hit`=1 on `done[3]` → `lives` 3 → 2 → 1 → 0. On the third hit, `state`=10 and `over`=1. Further ticks produce no requests.
- Second `vs` rise while busy → `overrun`=1, no restart. `reset_n` low mid-phase → every output at its reset value immediately.
